s35932_crc7_signature_unit: RTL and testbench

S35932_CRC7_SIGNATURE_UNIT -- requirements
Module: s35932_crc7_signature_unit

---
 rtl/s35932_crc7_signature_unit.sv | 136 +++++++++++++
 tb/tb_s35932_crc7_signature_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/s35932_crc7_signature_unit.sv
// 32-bit MISR signature compactor: absorbs LEN data words, then serializes the
// signature MSB first and pulses DONE.
module s35932_crc7_signature_unit (
  input  logic        CK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  LEN,
  input  logic [31:0] DIN,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  output logic [31:0] CRC_OUT,
  output logic        SER_OUT,
  output logic        SER_VALID,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = 6;

  localparam logic [DW-1:0] TAPS = DW'(32'h0001_0811);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPACT = 2'd1;
  localparam logic [1:0] S_SHIFT   = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  logic [1:0]    r_state;
  logic [DW-1:0] r_crc;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_sh;
  logic [BW-1:0] r_bit;
  logic          r_ser_out;
  logic          r_ser_valid;
  logic          r_done;
  logic          r_busy;
  logic          r_din_ready;

  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_crc_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_sh_nxt;
  logic [BW-1:0] w_bit_nxt;
  logic          w_ser_out_nxt;
  logic          w_ser_valid_nxt;
  logic          w_done_nxt;
  logic [DW-1:0] w_misr;

  assign w_misr = {r_crc[DW-2:0], 1'b0} ^ DIN ^ (r_crc[DW-1] ? TAPS : '0);

  // Next-state and next-output logic; SHIFT spends its first cycle loading the shift register.
  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_cnt_nxt       = r_cnt;
    w_sh_nxt        = r_sh;
    w_bit_nxt       = r_bit;
    w_ser_out_nxt   = 1'b0;
    w_ser_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_crc_nxt   = '0;
          w_cnt_nxt   = LEN;
          w_bit_nxt   = '0;
          w_state_nxt = (LEN == '0) ? S_SHIFT : S_COMPACT;
        end
      end
      S_COMPACT: begin
        if (DIN_VALID && r_din_ready) begin
          w_crc_nxt = w_misr;
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (r_bit == '0) begin
          w_sh_nxt        = {r_crc[DW-2:0], 1'b0};
          w_ser_out_nxt   = r_crc[DW-1];
          w_ser_valid_nxt = 1'b1;
          w_bit_nxt       = BW'(1);
        end else if (r_bit == BW'(DW)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_FINISH;
        end else begin
          w_sh_nxt        = {r_sh[DW-2:0], 1'b0};
          w_ser_out_nxt   = r_sh[DW-1];
          w_ser_valid_nxt = 1'b1;
          w_bit_nxt       = r_bit + BW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_crc       <= '0;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_bit       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_din_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sh        <= w_sh_nxt;
      r_bit       <= w_bit_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_din_ready <= (w_state_nxt == S_COMPACT);
    end
  end

  assign DIN_READY = r_din_ready;
  assign CRC_OUT   = r_crc;
  assign SER_OUT   = r_ser_out;
  assign SER_VALID = r_ser_valid;
  assign BUSY      = r_busy;
  assign DONE      = r_done;

endmodule

// File: tb/tb_s35932_crc7_signature_unit.sv
// Self-checking bench: directed vector table, reset-abort sequence and random runs
// against a bit-level MISR model, with a DONE-driven scoreboard.
module tb_s35932_crc7_signature_unit;

  logic        CK = 1'b0;
  logic        RESET;
  logic        START;
  logic [7:0]  LEN;
  logic [31:0] DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [31:0] CRC_OUT;
  logic        SER_OUT;
  logic        SER_VALID;
  logic        BUSY;
  logic        DONE;

  s35932_crc7_signature_unit dut (
    .CK(CK), .RESET(RESET), .START(START), .LEN(LEN), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .CRC_OUT(CRC_OUT),
    .SER_OUT(SER_OUT), .SER_VALID(SER_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CK = ~CK;

  typedef struct {
    int          len;
    int          gap;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] exp;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] words[256];
  logic [31:0] mon_word = '0;
  int          mon_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] o, input logic [31:0] d);
    logic [31:0] n;
    n[0] = o[31] ^ d[0];
    for (int i = 1; i < 32; i++)
      n[i] = o[i-1] ^ d[i] ^ (((i == 4) || (i == 11) || (i == 16)) ? o[31] : 1'b0);
    return n;
  endfunction

  function automatic logic [31:0] model_run(input int len);
    logic [31:0] c = '0;
    for (int i = 0; i < len; i++) c = misr(c, words[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Scoreboard: collects serial bits, compares on DONE against the queued signature.
  always @(negedge CK) begin
    if (RESET) begin
      mon_cnt  = 0;
      mon_word = '0;
    end else begin
      if (SER_VALID) begin
        mon_word = {mon_word[30:0], SER_OUT};
        mon_cnt++;
      end else if (SER_OUT !== 1'b0) begin
        check("ser_out_idle", 32'(SER_OUT), 32'd0);
      end
      if (DONE) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(DONE), 32'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("crc_at_done", CRC_OUT, e);
          check("ser_word", mon_word, e);
          check("ser_bits", 32'(mon_cnt), 32'd32);
        end
        mon_cnt  = 0;
        mon_word = '0;
      end
    end
  end

  task automatic run(input int len, input int gap, input bit noise, input logic [31:0] exp);
    logic [31:0] model;
    int k;
    exp_q.push_back(exp);
    START = 1'b1;
    LEN   = 8'(len);
    tick();
    START = 1'b0;
    if (noise) LEN = 8'($urandom);
    check("ready_after_start", 32'(DIN_READY), 32'(len != 0));
    model = '0;
    for (int i = 0; i < len; i++) begin
      int g;
      g = noise ? int'($urandom_range(0, 2)) : ((i > 0) ? gap : 0);
      for (int j = 0; j < g; j++) begin
        DIN_VALID = 1'b0;
        DIN       = $urandom;
        if (noise) START = 1'($urandom);
        tick();
        START = 1'b0;
        if (!noise) check("crc_hold_gap", CRC_OUT, model);
      end
      DIN       = words[i];
      DIN_VALID = 1'b1;
      k = 0;
      while (!DIN_READY && k < 8) begin
        tick();
        k++;
      end
      if (k == 8) check("ready_timeout", 32'(DIN_READY), 32'd1);
      tick();
      DIN_VALID = 1'b0;
      model = misr(model, words[i]);
      check("crc_accept", CRC_OUT, model);
    end
    k = 1;
    while (!DONE && k < 40) begin
      if (noise) begin
        START     = 1'($urandom);
        LEN       = 8'($urandom);
        DIN_VALID = 1'($urandom);
        DIN       = $urandom;
      end
      tick();
      k++;
    end
    START     = 1'b0;
    DIN_VALID = 1'b0;
    check("done_latency", 32'(k), 32'd34);
    tick();
    check("idle_busy", 32'(BUSY), 32'd0);
    check("crc_hold_idle", CRC_OUT, exp);
  endtask

  vec_t vecs[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; START = 1'b0; LEN = '0; DIN = '0; DIN_VALID = 1'b0;
    vecs[0] = '{len: 1, gap: 0, w0: 32'h0000_0001, w1: 32'h0, w2: 32'h0, exp: 32'h0000_0001};
    vecs[1] = '{len: 2, gap: 0, w0: 32'h8000_0000, w1: 32'h0, w2: 32'h0, exp: 32'h0001_0811};
    vecs[2] = '{len: 0, gap: 0, w0: 32'h0, w1: 32'h0, w2: 32'h0, exp: 32'h0000_0000};
    vecs[3] = '{len: 3, gap: 0, w0: 32'hA5A5_A5A5, w1: 32'h1234_5678, w2: 32'hFFFF_FFFF, exp: 32'h0};
    vecs[4] = '{len: 3, gap: 5, w0: 32'hA5A5_A5A5, w1: 32'h1234_5678, w2: 32'hFFFF_FFFF, exp: 32'h0};
    vecs[5] = '{len: 1, gap: 0, w0: 32'hFFFF_FFFF, w1: 32'h0, w2: 32'h0, exp: 32'hFFFF_FFFF};
    vecs[6] = '{len: 2, gap: 0, w0: 32'hFFFF_FFFF, w1: 32'h0, w2: 32'h0, exp: 32'hFFFE_F7EF};
    words[0] = 32'hA5A5_A5A5; words[1] = 32'h1234_5678; words[2] = 32'hFFFF_FFFF;
    vecs[3].exp = model_run(3);
    vecs[4].exp = vecs[3].exp;

    repeat (3) tick();
    RESET = 1'b0;
    check("rst_crc", CRC_OUT, 32'h0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ready", 32'(DIN_READY), 32'd0);
    check("rst_ser_valid", 32'(SER_VALID), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    tick();

    foreach (vecs[v]) begin
      words[0] = vecs[v].w0; words[1] = vecs[v].w1; words[2] = vecs[v].w2;
      run(vecs[v].len, vecs[v].gap, 1'b0, vecs[v].exp);
      tick();
    end

    // Reset in the 10th SHIFT cycle, with START asserted alongside it.
    START = 1'b1; LEN = 8'd1; tick();
    START = 1'b0; DIN = 32'h0000_0001; DIN_VALID = 1'b1; tick();
    DIN_VALID = 1'b0;
    repeat (9) tick();
    check("pre_abort_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1; START = 1'b1; LEN = 8'd3; tick();
    RESET = 1'b0; START = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_ser_valid", 32'(SER_VALID), 32'd0);
    check("abort_ser_out", 32'(SER_OUT), 32'd0);
    check("abort_crc", CRC_OUT, 32'h0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_ready", 32'(DIN_READY), 32'd0);
    repeat (40) tick();
    check("abort_stays_idle", 32'(BUSY), 32'd0);
    words[0] = 32'h0000_0001;
    run(1, 0, 1'b0, 32'h0000_0001);
    tick();

    for (int r = 0; r < 7; r++) begin
      int len;
      len = (r == 0) ? 255 : int'($urandom_range(1, 255));
      for (int i = 0; i < len; i++) words[i] = $urandom;
      run(len, 0, 1'b1, model_run(len));
      tick();
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
